// File: rtl/if_id_fetch_stage_if.sv
// rtl/if_id_fetch_stage_if.sv - instruction memory request/response bus
interface if_id_fetch_stage_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   gnt;
    logic                   rvalid;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - RV64I instruction fetch stage with integrated IF/ID register
module if_id_fetch_stage #(
    parameter int                      PC_WIDTH    = 64,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    if_id_fetch_stage_if.master    imem,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    input  logic                   stall_i,
    output logic                   id_valid_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [PC_WIDTH-1:0]    id_pc_plus4_o
);

    localparam logic [INSTR_WIDTH-1:0] NOP   = INSTR_WIDTH'(32'h0000_0013);
    localparam logic [PC_WIDTH-1:0]    FOUR  = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;

    logic                   handshake;
    logic                   id_load;
    logic [INSTR_WIDTH-1:0] id_instr_d;
    logic [PC_WIDTH-1:0]    id_pc_d;

    assign imem.req  = (state_q == S_FETCH) && rst_i;
    assign imem.addr = pc_q;
    assign handshake = imem.req && imem.gnt;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_load      = 1'b0;
        id_instr_d   = skid_instr_q;
        id_pc_d      = skid_pc_q;

        if (redirect_i) begin
            // A request already granted at the old PC must have its response swallowed in DROP.
            pc_d         = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            skid_valid_d = 1'b0;
            case (state_q)
                S_FETCH: state_d = handshake ? S_DROP : S_FETCH;
                S_WAIT:  state_d = imem.rvalid ? S_FETCH : S_DROP;
                S_HOLD:  state_d = S_FETCH;
                S_DROP:  state_d = imem.rvalid ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (handshake) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + FOUR;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall_i) begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem.rdata;
                            skid_pc_d    = fetch_pc_q;
                            state_d      = S_HOLD;
                        end else begin
                            id_load    = 1'b1;
                            id_instr_d = imem.rdata;
                            id_pc_d    = fetch_pc_q;
                            state_d    = S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        id_load      = skid_valid_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem.rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // IF/ID register: stall freezes everything, otherwise an empty cycle inserts a bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            id_valid_o    <= 1'b0;
            id_instr_o    <= NOP;
            id_pc_o       <= '0;
            id_pc_plus4_o <= FOUR;
        end else if (redirect_i) begin
            id_valid_o <= 1'b0;
        end else if (!stall_i) begin
            id_valid_o <= id_load;
            if (id_load) begin
                id_instr_o    <= id_instr_d;
                id_pc_o       <= id_pc_d;
                id_pc_plus4_o <= id_pc_d + FOUR;
            end
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - randomized bench for if_id_fetch_stage against a queue-based model
module tb_if_id_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [63:0] id_pc_o;
    logic [63:0] id_pc_plus4_o;

    if_id_fetch_stage_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) imem ();

    if_id_fetch_stage #(
        .PC_WIDTH   (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem         (imem),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .id_valid_o   (id_valid_o),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .id_pc_plus4_o(id_pc_plus4_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } fetch_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    // Reference: outstanding fetches and held responses as queues.
    fetch_t      m_infl[$];
    entry_t      m_skid[$];
    logic [63:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_idpc;

    bit          mem_busy;
    int          mem_lat;
    logic [63:0] mem_addr;

    int          n_delivered = 0;

    initial begin
        bit          m_req, hs, dut_hs, rv, stl, rd, have;
        logic [31:0] rdat, di;
        logic [63:0] tgt, dp;
        fetch_t      f;
        entry_t      e;

        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        stall_i       = 1'b0;
        imem.gnt      = 1'b0;
        imem.rvalid   = 1'b0;
        imem.rdata    = '0;
        m_pc     = 64'h0;
        m_valid  = 1'b0;
        m_instr  = 32'h0000_0013;
        m_idpc   = 64'h0;
        mem_busy = 1'b0;
        mem_lat  = 0;
        mem_addr = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_req", imem.req, 1'b0);
        chk("reset_id_valid", id_valid_o, 1'b0);
        chk("reset_id_instr", id_instr_o, 64'h13);
        chk("reset_id_pc", id_pc_o, 64'h0);
        chk("reset_id_pc_plus4", id_pc_plus4_o, 64'h4);

        rst_i = 1'b1;
        #1;
        chk("release_req", imem.req, 1'b1);
        chk("release_addr", imem.addr, 64'h0);
        @(posedge clk_i);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            m_req = (m_infl.size() == 0) && (m_skid.size() == 0);
            chk("req", imem.req, m_req);
            if (m_req) begin
                chk("addr", imem.addr, m_pc);
                chk("addr_align", imem.addr[1:0], 2'b00);
            end
            chk("id_valid", id_valid_o, m_valid);
            chk("id_instr", id_instr_o, m_instr);
            chk("id_pc", id_pc_o, m_idpc);
            chk("id_pc_plus4", id_pc_plus4_o, m_idpc + 64'd4);
            if (id_valid_o) n_delivered++;

            imem.gnt    = ($urandom_range(0, 3) != 0);
            rv          = mem_busy && (mem_lat == 0);
            imem.rvalid = rv;
            imem.rdata  = rv ? mem_word(mem_addr) : $urandom;
            stl         = ($urandom_range(0, 4) == 0);
            rd          = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                1:       tgt = 64'h103;
                default: tgt = {$urandom, $urandom};
            endcase
            stall_i       = stl;
            redirect_i    = rd;
            redirect_pc_i = tgt;
            rdat          = imem.rdata;
            hs            = m_req && imem.gnt;
            dut_hs        = imem.req && imem.gnt;

            @(posedge clk_i);
            #1;

            if (rv) mem_busy = 1'b0;
            else if (mem_busy) mem_lat--;
            if (dut_hs) begin
                mem_busy = 1'b1;
                mem_lat  = $urandom_range(0, 2);
                mem_addr = m_req ? m_pc : imem.addr;
            end

            have = 1'b0;
            di   = '0;
            dp   = '0;
            if (rd) begin
                if (rv && m_infl.size() > 0) void'(m_infl.pop_front());
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                if (hs) m_infl.push_back('{pc: m_pc, stale: 1'b1});
                m_skid.delete();
                m_valid = 1'b0;
                m_pc    = tgt & ~64'h3;
            end else begin
                if (rv && m_infl.size() > 0) begin
                    f = m_infl.pop_front();
                    if (!f.stale) begin
                        if (stl) m_skid.push_back('{instr: rdat, pc: f.pc});
                        else begin
                            have = 1'b1;
                            di   = rdat;
                            dp   = f.pc;
                        end
                    end
                end else if (m_skid.size() > 0 && !stl) begin
                    e    = m_skid.pop_front();
                    have = 1'b1;
                    di   = e.instr;
                    dp   = e.pc;
                end
                if (hs) begin
                    m_infl.push_back('{pc: m_pc, stale: 1'b0});
                    m_pc = m_pc + 64'd4;
                end
                if (!stl) begin
                    m_valid = have;
                    if (have) begin
                        m_instr = di;
                        m_idpc  = dp;
                    end
                end
            end
        end

        chk("liveness", (n_delivered > 100) ? 64'd1 : 64'd0, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
